// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg: cartridge bus states, address map constants and the shared address decode
package gb_bus_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam logic [15:0] CART_ROM_END = 16'h8000;
  localparam logic [15:0] EXTRAM_BASE = 16'hA000;
  localparam logic [15:0] EXTRAM_END = 16'hBFFF;
  localparam logic [7:0] OPEN_BUS = 8'hFF;
  typedef struct packed {
    logic in_rom;
    logic in_ram;
  } decode_t;
  function automatic decode_t decode(input logic [15:0] addr);
    decode_t d;
    d.in_rom = addr < CART_ROM_END;
    d.in_ram = addr >= EXTRAM_BASE && addr <= EXTRAM_END;
    return d;
  endfunction
endpackage

// File: rtl/cart_bus_master_if.sv
// cart_bus_master_if: system-side request/response bus of the cartridge bus master
//   req_valid/req_ready/req_addr/req_we/req_wdata: single-byte request handshake
//   rsp_valid/rsp_rdata: one-cycle completion pulse with read data
interface cart_bus_master_if;
  logic req_valid;
  logic req_ready;
  logic [15:0] req_addr;
  logic req_we;
  logic [7:0] req_wdata;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input req_valid, req_addr, req_we, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cart_bus_master.sv
// cart_bus_master: sequences single-byte system requests onto the cartridge edge connector
//   clk, rst_n: clock and asynchronous active-low reset
//   bus: request/response handshake (slave side)
//   cart_addr/cart_dout/cart_doe/cart_din: cartridge address and data pins
//   cart_rd_n/cart_wr_n/cart_cs_n: active-low strobes and external RAM select, all registered
module cart_bus_master
  import gb_bus_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input logic clk,
  input logic rst_n,
  cart_bus_master_if.slave bus,
  output logic [15:0] cart_addr,
  output logic [7:0] cart_dout,
  output logic cart_doe,
  input logic [7:0] cart_din,
  output logic cart_rd_n,
  output logic cart_wr_n,
  output logic cart_cs_n
);
  localparam int MAXC = SETUP_CYCLES > STROBE_CYCLES ?
    (SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES) :
    (STROBE_CYCLES > HOLD_CYCLES ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic we;
  logic ready;
  logic rsp_valid;
  logic [7:0] rsp_rdata;
  decode_t dec;
  assign dec = decode(bus.req_addr);
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      cart_addr <= 16'h0000;
      cart_dout <= 8'h00;
      cart_doe <= 1'b0;
      cart_rd_n <= 1'b1;
      cart_wr_n <= 1'b1;
      cart_cs_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.req_valid && ready) begin
          ready <= 1'b0;
          if (dec.in_rom || dec.in_ram) begin
            state <= SETUP;
            cnt <= SETUP_LD;
            we <= bus.req_we;
            cart_addr <= bus.req_addr;
            cart_cs_n <= !dec.in_ram;
            cart_doe <= bus.req_we;
            if (bus.req_we) cart_dout <= bus.req_wdata;
          end else begin
            // unmapped addresses complete at once with open-bus data, pins untouched
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= OPEN_BUS;
          end
        end
        SETUP: if (cnt == '0) begin
          state <= STROBE;
          cnt <= STROBE_LD;
          cart_rd_n <= we;
          cart_wr_n <= !we;
        end else cnt <= cnt - CW'(1);
        STROBE: if (cnt == '0) begin
          // read data is sampled on the edge that ends the last strobe cycle
          state <= HOLD;
          cnt <= HOLD_LD;
          cart_rd_n <= 1'b1;
          cart_wr_n <= 1'b1;
          if (!we) rsp_rdata <= cart_din;
        end else cnt <= cnt - CW'(1);
        HOLD: if (cnt == '0) begin
          state <= DONE;
          rsp_valid <= 1'b1;
          cart_cs_n <= 1'b1;
          cart_doe <= 1'b0;
        end else cnt <= cnt - CW'(1);
        DONE: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cart_bus_master.sv
// tb_cart_bus_master: directed self-checking bench for cart_bus_master at default and 3/4/2 timing
module tb_cart_bus_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] cart_din = 8'h00;
  logic [15:0] a_addr, b_addr;
  logic [7:0] a_dout, b_dout;
  logic a_doe, b_doe, a_rd_n, b_rd_n, a_wr_n, b_wr_n, a_cs_n, b_cs_n;
  int tests = 0;
  int fails = 0;
  cart_bus_master_if a();
  cart_bus_master_if b();
  cart_bus_master dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a),
    .cart_addr(a_addr), .cart_dout(a_dout), .cart_doe(a_doe), .cart_din(cart_din),
    .cart_rd_n(a_rd_n), .cart_wr_n(a_wr_n), .cart_cs_n(a_cs_n)
  );
  cart_bus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b),
    .cart_addr(b_addr), .cart_dout(b_dout), .cart_doe(b_doe), .cart_din(cart_din),
    .cart_rd_n(b_rd_n), .cart_wr_n(b_wr_n), .cart_cs_n(b_cs_n)
  );
  always #5 clk = ~clk;

  // present a request, let it be accepted on the next edge, return at the cycle-1 negedge
  task automatic start_a(input logic [15:0] ad, input logic w, input logic [7:0] wd);
    @(negedge clk);
    a.req_addr = ad; a.req_we = w; a.req_wdata = wd; a.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a.req_valid = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] ad, input logic w, input logic [7:0] wd);
    @(negedge clk);
    b.req_addr = ad; b.req_we = w; b.req_wdata = wd; b.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    a.req_valid = 0; a.req_addr = 0; a.req_we = 0; a.req_wdata = 0;
    b.req_valid = 0; b.req_addr = 0; b.req_we = 0; b.req_wdata = 0;
    rst_n = 1'b0;
    #12;
    got = {a.req_ready, a.rsp_valid, a.rsp_rdata, a_doe, a_rd_n, a_wr_n, a_cs_n};
    exp = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_ctrl got %h exp %h", got, exp); end
    tests++;
    if (a_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h exp 0000", a_addr); end
    tests++;
    if (a_dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h exp 00", a_dout); end
    tests++;
    if (b.req_ready !== 1'b1 || b_rd_n !== 1'b1) begin
      fails++; $display("FAIL reset_b got ready %b rd_n %b exp 1 1", b.req_ready, b_rd_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    cart_din = 8'h3C;
    start_a(16'h0150, 1'b0, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (a_rd_n !== !(k == 2 || k == 3)) begin
        fails++; $display("FAIL read_rd_n cyc%0d got %b exp %b", k, a_rd_n, !(k == 2 || k == 3));
      end
      tests++;
      if (a_cs_n !== 1'b1 || a_doe !== 1'b0 || a_wr_n !== 1'b1) begin
        fails++; $display("FAIL read_pins cyc%0d got cs_n %b doe %b wr_n %b exp 1 0 1", k, a_cs_n, a_doe, a_wr_n);
      end
      tests++;
      if (a.rsp_valid !== (k == 5)) begin
        fails++; $display("FAIL read_rsp_valid cyc%0d got %b exp %b", k, a.rsp_valid, k == 5);
      end
      if (k <= 4) begin
        tests++;
        if (a_addr !== 16'h0150) begin fails++; $display("FAIL read_addr cyc%0d got %h exp 0150", k, a_addr); end
      end
      if (k == 5) begin
        tests++;
        if (a.rsp_rdata !== 8'h3C) begin fails++; $display("FAIL read_rdata got %h exp 3c", a.rsp_rdata); end
      end
    end
  endtask

  task automatic test_write;
    start_a(16'hA123, 1'b1, 8'h5A);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (a_wr_n !== !(k == 2 || k == 3) || a_rd_n !== 1'b1) begin
        fails++; $display("FAIL write_strobe cyc%0d got wr_n %b rd_n %b exp %b 1", k, a_wr_n, a_rd_n, !(k == 2 || k == 3));
      end
      tests++;
      if (a_cs_n !== !(k <= 4) || a_doe !== (k <= 4)) begin
        fails++; $display("FAIL write_cs_doe cyc%0d got cs_n %b doe %b exp %b %b", k, a_cs_n, a_doe, !(k <= 4), k <= 4);
      end
      if (k <= 4) begin
        tests++;
        if (a_dout !== 8'h5A || a_addr !== 16'hA123) begin
          fails++; $display("FAIL write_bus cyc%0d got dout %h addr %h exp 5a a123", k, a_dout, a_addr);
        end
      end
      tests++;
      if (a.rsp_valid !== (k == 5)) begin
        fails++; $display("FAIL write_rsp_valid cyc%0d got %b exp %b", k, a.rsp_valid, k == 5);
      end
      if (k == 5) begin
        tests++;
        if (a.rsp_rdata !== 8'h3C) begin fails++; $display("FAIL write_rdata_kept got %h exp 3c", a.rsp_rdata); end
      end
    end
  endtask

  task automatic test_open_bus;
    start_a(16'hC000, 1'b0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (a.rsp_valid !== (k == 1)) begin
        fails++; $display("FAIL open_rsp_valid cyc%0d got %b exp %b", k, a.rsp_valid, k == 1);
      end
      tests++;
      if (a_rd_n !== 1'b1 || a_wr_n !== 1'b1 || a_cs_n !== 1'b1 || a_addr !== 16'hA123) begin
        fails++; $display("FAIL open_pins cyc%0d got rd_n %b wr_n %b cs_n %b addr %h exp 1 1 1 a123", k, a_rd_n, a_wr_n, a_cs_n, a_addr);
      end
      if (k == 1) begin
        tests++;
        if (a.rsp_rdata !== 8'hFF) begin fails++; $display("FAIL open_rdata got %h exp ff", a.rsp_rdata); end
      end
      if (k == 2) begin
        tests++;
        if (a.req_ready !== 1'b1) begin fails++; $display("FAIL open_ready got %b exp 1", a.req_ready); end
      end
    end
  endtask

  task automatic test_back_to_back;
    cart_din = 8'h91;
    @(negedge clk);
    a.req_addr = 16'h4000; a.req_we = 1'b0; a.req_wdata = 8'h00; a.req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (a.req_ready !== (k == 6 || k == 12)) begin
        fails++; $display("FAIL b2b_ready cyc%0d got %b exp %b", k, a.req_ready, k == 6 || k == 12);
      end
      tests++;
      if (a.rsp_valid !== (k == 5 || k == 11)) begin
        fails++; $display("FAIL b2b_rsp_valid cyc%0d got %b exp %b", k, a.rsp_valid, k == 5 || k == 11);
      end
      tests++;
      if (a_rd_n !== !(k == 2 || k == 3) || a_wr_n !== !(k == 8 || k == 9)) begin
        fails++; $display("FAIL b2b_strobes cyc%0d got rd_n %b wr_n %b exp %b %b", k, a_rd_n, a_wr_n, !(k == 2 || k == 3), !(k == 8 || k == 9));
      end
      tests++;
      if (a_cs_n !== !(k >= 7 && k <= 10)) begin
        fails++; $display("FAIL b2b_cs_n cyc%0d got %b exp %b", k, a_cs_n, !(k >= 7 && k <= 10));
      end
      if (k == 5 || k == 11) begin
        tests++;
        if (a.rsp_rdata !== 8'h91) begin fails++; $display("FAIL b2b_rdata cyc%0d got %h exp 91", k, a.rsp_rdata); end
      end
      if (k == 8) begin
        tests++;
        if (a_addr !== 16'hB000 || a_dout !== 8'h77) begin
          fails++; $display("FAIL b2b_second got addr %h dout %h exp b000 77", a_addr, a_dout);
        end
      end
      if (k == 5) begin
        a.req_addr = 16'hB000; a.req_we = 1'b1; a.req_wdata = 8'h77;
      end
      if (k == 7) a.req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    start_a(16'hA010, 1'b1, 8'h22);
    @(negedge clk);
    tests++;
    if (a_wr_n !== 1'b0 || a_cs_n !== 1'b0 || a_doe !== 1'b1) begin
      fails++; $display("FAIL mid_pre got wr_n %b cs_n %b doe %b exp 0 0 1", a_wr_n, a_cs_n, a_doe);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (a_wr_n !== 1'b1 || a_cs_n !== 1'b1 || a_doe !== 1'b0 || a_rd_n !== 1'b1) begin
      fails++; $display("FAIL mid_async got wr_n %b cs_n %b doe %b rd_n %b exp 1 1 0 1", a_wr_n, a_cs_n, a_doe, a_rd_n);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests++;
      if (a.rsp_valid !== 1'b0 || a.req_ready !== 1'b1 || a_wr_n !== 1'b1) begin
        fails++; $display("FAIL mid_after cyc%0d got rsp_valid %b ready %b wr_n %b exp 0 1 1", k, a.rsp_valid, a.req_ready, a_wr_n);
      end
    end
  endtask

  task automatic test_timing;
    cart_din = 8'hAA;
    start_b(16'h1234, 1'b0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      tests++;
      if (b_rd_n !== !(k >= 4 && k <= 7)) begin
        fails++; $display("FAIL timing_rd_n cyc%0d got %b exp %b", k, b_rd_n, !(k >= 4 && k <= 7));
      end
      tests++;
      if (b.rsp_valid !== (k == 10)) begin
        fails++; $display("FAIL timing_rsp_valid cyc%0d got %b exp %b", k, b.rsp_valid, k == 10);
      end
      if (k == 10) begin
        tests++;
        if (b.rsp_rdata !== 8'h55) begin fails++; $display("FAIL timing_rdata got %h exp 55", b.rsp_rdata); end
      end
      if (k == 7) cart_din = 8'h55;
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_open_bus;
    test_back_to_back;
    test_reset_mid;
    test_timing;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
